// File: rtl/cpu_mpu_fault.sv
// ---------------------------------------------------------------------------
// cpu_mpu_fault
//
// Fault-capture stage that sits directly after the MPU. The MPU reports its
// load/store fault flags one cycle after it sees the address, so the p3
// address and PC are delayed into p4 registers to line up with the flags.
// The first accepted (unflushed) fault is captured with its address, PC and
// cause, and a held exception request is raised until the core acknowledges
// it. Overflow and saturating fault-count statistics are kept for supervisor
// software and are cleared through the CFG write-1 pulse.
//
// Ports:
//   clock           in   system clock, rising edge
//   reset           in   asynchronous active-low reset
//   p3_mem_request  in   p3 memory access valid
//   p3_mem_addr     in   p3 access address (as presented to the MPU)
//   p3_pc           in   PC of the p3 instruction
//   p4_load_fault   in   MPU load fault for last cycle's p3 access
//   p4_store_fault  in   MPU store fault, same timing
//   p4_flush        in   p4 instruction killed; its fault is ignored
//   exc_ack         in   core has taken the exception (one-cycle pulse)
//   cfg_clear       in   clear status and statistics (one-cycle pulse)
//   exc_req         out  exception request, held until acknowledged
//   fault_addr      out  captured faulting address
//   fault_pc        out  captured faulting PC
//   fault_cause     out  0 none, 1 load, 2 store
//   fault_overflow  out  sticky: another fault arrived while one was held
//   fault_count     out  accepted faults, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module cpu_mpu_fault (
    input  logic        clock,
    input  logic        reset,
    input  logic        p3_mem_request,
    input  logic [31:0] p3_mem_addr,
    input  logic [31:0] p3_pc,
    input  logic        p4_load_fault,
    input  logic        p4_store_fault,
    input  logic        p4_flush,
    input  logic        exc_ack,
    input  logic        cfg_clear,
    output logic        exc_req,
    output logic [31:0] fault_addr,
    output logic [31:0] fault_pc,
    output logic [1:0]  fault_cause,
    output logic        fault_overflow,
    output logic [15:0] fault_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        HELD    = 2'd2
    } state_t;

    localparam logic [1:0]  CAUSE_NONE  = 2'd0;
    localparam logic [1:0]  CAUSE_LOAD  = 2'd1;
    localparam logic [1:0]  CAUSE_STORE = 2'd2;
    localparam logic [15:0] COUNT_MAX   = 16'hFFFF;

    state_t      state;
    state_t      state_next;
    logic [31:0] p4_addr;
    logic [31:0] p4_pc;
    logic        afault;
    logic [1:0]  cause_new;
    logic        capture;
    logic        exc_req_next;
    logic [1:0]  cause_next;
    logic        overflow_next;
    logic [15:0] count_base;
    logic [15:0] count_next;

    // p3 -> p4 boundary: address/PC follow the access so they line up with
    // the MPU flags that arrive one cycle later.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            p4_addr <= '0;
            p4_pc   <= '0;
        end else if (p3_mem_request) begin
            p4_addr <= p3_mem_addr;
            p4_pc   <= p3_pc;
        end
    end

    assign afault    = (p4_load_fault | p4_store_fault) & ~p4_flush;
    // Store wins when the MPU flags both.
    assign cause_new = p4_store_fault ? CAUSE_STORE : CAUSE_LOAD;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A clear in PENDING does not cancel the request; a
    // clear in HELD frees the capture slot, so a same-cycle fault re-arms.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (afault)    state_next = PENDING;
            PENDING: if (exc_ack)   state_next = HELD;
            HELD:    if (cfg_clear) state_next = afault ? PENDING : IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Output / datapath next values. The clear is applied first and the
    // fault event is then layered on top of the cleared values.
    always_comb begin
        capture       = afault && ((state == IDLE) || ((state == HELD) && cfg_clear));
        exc_req_next  = (state_next == PENDING);

        cause_next = fault_cause;
        if (capture) begin
            cause_next = cause_new;
        end else if ((state == HELD) && cfg_clear) begin
            cause_next = CAUSE_NONE;
        end

        overflow_next = (cfg_clear ? 1'b0 : fault_overflow) | (afault & ~capture);

        count_base = cfg_clear ? 16'd0 : fault_count;
        count_next = count_base;
        if (afault && (count_base != COUNT_MAX)) begin
            count_next = count_base + 16'd1;
        end
    end

    // Output registers: every output comes straight from a flop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            exc_req        <= 1'b0;
            fault_addr     <= '0;
            fault_pc       <= '0;
            fault_cause    <= CAUSE_NONE;
            fault_overflow <= 1'b0;
            fault_count    <= '0;
        end else begin
            exc_req        <= exc_req_next;
            fault_cause    <= cause_next;
            fault_overflow <= overflow_next;
            fault_count    <= count_next;
            if (capture) begin
                fault_addr <= p4_addr;
                fault_pc   <= p4_pc;
            end
        end
    end

endmodule

// File: tb/tb_cpu_mpu_fault.sv
// ---------------------------------------------------------------------------
// tb_cpu_mpu_fault
//
// Self-checking bench for cpu_mpu_fault. Each scenario task pushes the
// expected output snapshot when it drives the stimulus and pops/compares it
// once the DUT has clocked the result out.
// ---------------------------------------------------------------------------
module tb_cpu_mpu_fault;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        p3_mem_request = 1'b0;
    logic [31:0] p3_mem_addr = '0;
    logic [31:0] p3_pc = '0;
    logic        p4_load_fault = 1'b0;
    logic        p4_store_fault = 1'b0;
    logic        p4_flush = 1'b0;
    logic        exc_ack = 1'b0;
    logic        cfg_clear = 1'b0;
    logic        exc_req;
    logic [31:0] fault_addr;
    logic [31:0] fault_pc;
    logic [1:0]  fault_cause;
    logic        fault_overflow;
    logic [15:0] fault_count;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [1:0]  cause;
        logic        ovf;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [83:0] act;
    int          vectors = 0;
    int          miscompares = 0;

    cpu_mpu_fault dut (
        .clock          (clock),
        .reset          (reset),
        .p3_mem_request (p3_mem_request),
        .p3_mem_addr    (p3_mem_addr),
        .p3_pc          (p3_pc),
        .p4_load_fault  (p4_load_fault),
        .p4_store_fault (p4_store_fault),
        .p4_flush       (p4_flush),
        .exc_ack        (exc_ack),
        .cfg_clear      (cfg_clear),
        .exc_req        (exc_req),
        .fault_addr     (fault_addr),
        .fault_pc       (fault_pc),
        .fault_cause    (fault_cause),
        .fault_overflow (fault_overflow),
        .fault_count    (fault_count)
    );

    always #5 clock = ~clock;

    assign act = {exc_req, fault_addr, fault_pc, fault_cause, fault_overflow, fault_count};

    function automatic exp_t mk(input logic r, input logic [31:0] a, input logic [31:0] p,
                                input logic [1:0] c, input logic o, input logic [15:0] n);
        mk = {r, a, p, c, o, n};
    endfunction

    task automatic drive(input logic req, input logic [31:0] a, input logic [31:0] p,
                         input logic ld, input logic st, input logic fl,
                         input logic ack, input logic clr);
        p3_mem_request = req;
        p3_mem_addr    = a;
        p3_pc          = p;
        p4_load_fault  = ld;
        p4_store_fault = st;
        p4_flush       = fl;
        exc_ack        = ack;
        cfg_clear      = clr;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        #1;
        sb.push_back(mk(0, 0, 0, 0, 0, 0));
        e = sb.pop_front(); vectors++;
        if (act !== e) begin miscompares++; $display("FAIL reset_values: got %h required %h", act, e); end
        reset = 1'b1;
        sb.push_back(mk(0, 0, 0, 0, 0, 0));
        tick();
        e = sb.pop_front(); vectors++;
        if (act !== e) begin miscompares++; $display("FAIL idle_after_reset: got %h required %h", act, e); end
    endtask

    task automatic test_load_fault();
        drive(1, 32'h0001_2340, 32'h100, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        sb.push_back(mk(1, 32'h0001_2340, 32'h100, 1, 0, 1));
        tick();
        e = sb.pop_front(); vectors++;
        if (act !== e) begin miscompares++; $display("FAIL load_capture: got %h required %h", act, e); end
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        sb.push_back(mk(0, 32'h0001_2340, 32'h100, 1, 0, 1));
        tick();
        e = sb.pop_front(); vectors++;
        if (act !== e) begin miscompares++; $display("FAIL ack_drops_req: got %h required %h", act, e); end
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        sb.push_back(mk(0, 32'h0001_2340, 32'h100, 0, 0, 0));
        tick();
        e = sb.pop_front(); vectors++;
        if (act !== e) begin miscompares++; $display("FAIL held_clear: got %h required %h", act, e); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_flushed_fault();
        drive(1, 32'h5550, 32'h200, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 1, 0, 0);
        sb.push_back(mk(0, 32'h0001_2340, 32'h100, 0, 0, 0));
        tick();
        e = sb.pop_front(); vectors++;
        if (act !== e) begin miscompares++; $display("FAIL flushed_store: got %h required %h", act, e); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        sb.push_back(mk(0, 32'h0001_2340, 32'h100, 0, 0, 0));
        tick();
        e = sb.pop_front(); vectors++;
        if (act !== e) begin miscompares++; $display("FAIL flushed_no_late_req: got %h required %h", act, e); end
    endtask

    task automatic test_overflow_pending();
        drive(1, 32'h2000, 32'h300, 0, 0, 0, 0, 0);
        tick();
        drive(1, 32'h3000, 32'h304, 0, 1, 0, 0, 0);
        sb.push_back(mk(1, 32'h2000, 32'h300, 2, 0, 1));
        tick();
        e = sb.pop_front(); vectors++;
        if (act !== e) begin miscompares++; $display("FAIL store_capture: got %h required %h", act, e); end
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        sb.push_back(mk(1, 32'h2000, 32'h300, 2, 1, 2));
        tick();
        e = sb.pop_front(); vectors++;
        if (act !== e) begin miscompares++; $display("FAIL pending_overflow: got %h required %h", act, e); end
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        sb.push_back(mk(1, 32'h2000, 32'h300, 2, 0, 0));
        tick();
        e = sb.pop_front(); vectors++;
        if (act !== e) begin miscompares++; $display("FAIL pending_clear_keeps_req: got %h required %h", act, e); end
        drive(0, 0, 0, 1, 0, 0, 1, 0);
        sb.push_back(mk(0, 32'h2000, 32'h300, 2, 1, 1));
        tick();
        e = sb.pop_front(); vectors++;
        if (act !== e) begin miscompares++; $display("FAIL ack_with_fault: got %h required %h", act, e); end
    endtask

    task automatic test_held_clear_fault();
        drive(1, 32'h4000, 32'h400, 0, 1, 0, 0, 0);
        sb.push_back(mk(0, 32'h2000, 32'h300, 2, 1, 2));
        tick();
        e = sb.pop_front(); vectors++;
        if (act !== e) begin miscompares++; $display("FAIL held_fault_no_capture: got %h required %h", act, e); end
        drive(0, 0, 0, 1, 0, 0, 0, 1);
        sb.push_back(mk(1, 32'h4000, 32'h400, 1, 0, 1));
        tick();
        e = sb.pop_front(); vectors++;
        if (act !== e) begin miscompares++; $display("FAIL held_clear_and_fault: got %h required %h", act, e); end
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        sb.push_back(mk(0, 32'h4000, 32'h400, 1, 0, 1));
        tick();
        e = sb.pop_front(); vectors++;
        if (act !== e) begin miscompares++; $display("FAIL ack_rearmed: got %h required %h", act, e); end
        sb.push_back(mk(0, 32'h4000, 32'h400, 1, 0, 1));
        tick();
        e = sb.pop_front(); vectors++;
        if (act !== e) begin miscompares++; $display("FAIL ack_in_held_ignored: got %h required %h", act, e); end
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        sb.push_back(mk(0, 32'h4000, 32'h400, 0, 0, 0));
        tick();
        e = sb.pop_front(); vectors++;
        if (act !== e) begin miscompares++; $display("FAIL clear_to_idle: got %h required %h", act, e); end
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        sb.push_back(mk(0, 32'h4000, 32'h400, 0, 0, 0));
        tick();
        e = sb.pop_front(); vectors++;
        if (act !== e) begin miscompares++; $display("FAIL ack_in_idle_ignored: got %h required %h", act, e); end
    endtask

    task automatic test_back_to_back();
        drive(1, 32'h6000, 32'h600, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 1, 0, 0, 1);
        sb.push_back(mk(1, 32'h6000, 32'h600, 2, 0, 1));
        tick();
        e = sb.pop_front(); vectors++;
        if (act !== e) begin miscompares++; $display("FAIL idle_clear_fault_store_prio: got %h required %h", act, e); end
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        sb.push_back(mk(0, 32'h6000, 32'h600, 0, 0, 0));
        tick();
        e = sb.pop_front(); vectors++;
        if (act !== e) begin miscompares++; $display("FAIL ack_clear_sequence: got %h required %h", act, e); end
    endtask

    task automatic test_async_reset();
        drive(1, 32'h7000, 32'h700, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        sb.push_back(mk(1, 32'h7000, 32'h700, 1, 0, 1));
        tick();
        e = sb.pop_front(); vectors++;
        if (act !== e) begin miscompares++; $display("FAIL pending_before_reset: got %h required %h", act, e); end
        sb.push_back(mk(1, 32'h7000, 32'h700, 1, 1, 2));
        tick();
        e = sb.pop_front(); vectors++;
        if (act !== e) begin miscompares++; $display("FAIL overflow_before_reset: got %h required %h", act, e); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        sb.push_back(mk(0, 0, 0, 0, 0, 0));
        e = sb.pop_front(); vectors++;
        if (act !== e) begin miscompares++; $display("FAIL async_reset_no_edge: got %h required %h", act, e); end
        tick();
        reset = 1'b1;
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        sb.push_back(mk(1, 0, 0, 1, 0, 1));
        tick();
        e = sb.pop_front(); vectors++;
        if (act !== e) begin miscompares++; $display("FAIL fault_after_reset_p4_zero: got %h required %h", act, e); end
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        drive(1, 32'h8000, 32'h800, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        sb.push_back(mk(1, 32'h8000, 32'h800, 2, 0, 1));
        tick();
        e = sb.pop_front(); vectors++;
        if (act !== e) begin miscompares++; $display("FAIL capture_after_reset: got %h required %h", act, e); end
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_saturation();
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        repeat (65534) tick();
        sb.push_back(mk(1, 32'h8000, 32'h800, 1, 1, 16'hFFFF));
        tick();
        e = sb.pop_front(); vectors++;
        if (act !== e) begin miscompares++; $display("FAIL count_reaches_max: got %h required %h", act, e); end
        sb.push_back(mk(1, 32'h8000, 32'h800, 1, 1, 16'hFFFF));
        tick();
        e = sb.pop_front(); vectors++;
        if (act !== e) begin miscompares++; $display("FAIL count_saturates: got %h required %h", act, e); end
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        sb.push_back(mk(1, 32'h8000, 32'h800, 1, 0, 0));
        tick();
        e = sb.pop_front(); vectors++;
        if (act !== e) begin miscompares++; $display("FAIL clear_from_saturated: got %h required %h", act, e); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_load_fault();
        test_flushed_fault();
        test_overflow_pending();
        test_held_clear_fault();
        test_back_to_back();
        test_async_reset();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpu_mpu_fault.md
# cpu_mpu_fault

Fault-capture stage directly downstream of the MPU. Pipelines the p3 access address and PC alongside the MPU's one-cycle-late fault flags and records the first unmasked fault: address, PC and cause. It raises a held exception request to the pipeline until the core acknowledges it. It also keeps overflow and count statistics for supervisor software, read through the CFG registers.

## Interface
- No parameters.
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (low = reset asserted).
- p3_mem_request  in  1  p3 memory access valid.
- p3_mem_addr  in  32  p3 access address (same value presented to MPU).
- p3_pc  in  32  PC of the p3 instruction.
- p4_load_fault  in  1  MPU load fault for the access that was in p3 last cycle.
- p4_store_fault  in  1  MPU store fault, same timing.
- p4_flush  in  1  instruction in p4 is killed; its fault is ignored.
- exc_ack  in  1  core has taken the exception (single-cycle pulse).
- cfg_clear  in  1  CFG write-1 pulse: clear status and stats.
- exc_req  out  1  exception request to pipeline, held until ack.
- fault_addr  out  32  captured faulting address.
- fault_pc  out  32  captured faulting PC.
- fault_cause  out  2  0 = none, 1 = load, 2 = store (3 never driven).
- fault_overflow  out  1  sticky: a further fault occurred while one was held.
- fault_count  out  16  total accepted faults, saturating.

## Operation
- p4 registers: p4_addr and p4_pc load p3_mem_addr and p3_pc on every clock in which p3_mem_request = 1, and hold otherwise. They are needed because the MPU flags arrive one cycle after the address.
- Accepted fault ("afault"): (p4_load_fault | p4_store_fault) & ~p4_flush.
- Cause: if p4_store_fault = 1, cause is store (2), even if p4_load_fault is also set. Otherwise cause is load (1).
- FSM states: IDLE, PENDING, HELD.
  - IDLE + afault: capture p4_addr, p4_pc and cause, then go to PENDING.
  - PENDING: exc_req = 1. On exc_ack, go to HELD.
  - HELD: exc_req = 0. Captured info stays stable for software. cfg_clear goes to IDLE.
- Afault in PENDING or HELD: captured info is not overwritten and fault_overflow is set to 1.
- fault_count increments by 1 on every afault in every state and saturates at 16'hFFFF (no wrap).
- cfg_clear, in any state:
  - fault_overflow <= 0 and fault_count <= 0.
  - In HELD only: fault_cause <= 0 and the state goes to IDLE. fault_addr and fault_pc keep their last values.
  - In PENDING: the state is unchanged. The request cannot be cancelled by software.
- Simultaneous events:
  - PENDING + exc_ack + afault: go to HELD, overflow set, count incremented.
  - HELD + cfg_clear + afault: the new fault is captured and the state goes to PENDING. Overflow ends at 0 and count ends at 1 (clear first, then the event applies).
  - IDLE + cfg_clear + afault: capture, go to PENDING, count = 1, overflow = 0.
- exc_ack in IDLE or HELD is ignored.

## Timing
- Reset values: exc_req = 0, fault_addr = 0, fault_pc = 0, fault_cause = 0, fault_overflow = 0, fault_count = 0, state = IDLE, p4_addr = p4_pc = 0.
- Reset is asynchronous on assertion. Release is synchronised externally, and the first active edge after release is normal operation.
- Reset asserted mid-PENDING: exc_req drops immediately (asynchronously) and no capture survives.
- Latency:
  - Access in p3 at cycle N, fault flag at cycle N+1: exc_req and the captured registers are valid from cycle N+2, all registered outputs.
  - exc_ack at cycle M: exc_req = 0 from cycle M+1.
  - cfg_clear at cycle K: cleared values visible at K+1.
- All outputs are driven directly from flops; there are no combinational paths from inputs to outputs.

## Test plan
- Load fault: p3 addr 0x0001_2340, pc 0x100, fault at N+1 -> at N+2: exc_req = 1, fault_addr = 0x0001_2340, fault_pc = 0x100, cause = 1, count = 1. Ack -> exc_req = 0 next cycle, state HELD.
- Flushed fault: store fault with p4_flush = 1 -> exc_req stays 0, count stays 0, cause = 0.
- Second fault while PENDING: store fault at 0x2000, then load fault at 0x3000 before ack -> addr stays 0x2000, cause = 2, overflow = 1, count = 2.
- HELD + cfg_clear + new fault in the same cycle at 0x4000 -> next cycle: PENDING, exc_req = 1, addr = 0x4000, overflow = 0, count = 1.
- Saturation: 65 536 faults with acks and clears suppressed -> count holds 0xFFFF; cfg_clear -> 0.
- Async reset asserted while PENDING with overflow set -> all outputs 0 without a clock edge. After release, a new fault captures normally.
